// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the uart transmit arbiter: FSM states and per-frame
// configuration encodings as the transmitter consumes them.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} arb_state_e;

  typedef enum logic [1:0] {
    FRAME_5 = 2'b00,
    FRAME_6 = 2'b01,
    FRAME_7 = 2'b10,
    FRAME_8 = 2'b11
  } frame_type_e;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_type_e;

  typedef struct packed {
    frame_type_e  frame;
    parity_type_e parity;
    logic         stop;
  } tx_cfg_t;

  localparam frame_type_e FRAME_RST = FRAME_8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Handshake and frame configuration between the arbiter and the uart transmitter.
interface uart_tx_arbiter_if;
  import uart_pkg::*;

  logic         tx_req;
  logic [7:0]   tx_data;
  frame_type_e  tx_frame_type;
  parity_type_e tx_parity_type;
  logic         tx_stop_type;
  logic         tx_busy;
  logic         tx_clr;

  modport master (
    output tx_req, tx_data, tx_frame_type, tx_parity_type, tx_stop_type,
    input  tx_busy, tx_clr
  );

  modport slave (
    input  tx_req, tx_data, tx_frame_type, tx_parity_type, tx_stop_type,
    output tx_busy, tx_clr
  );

endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first eligible index strictly after ptr,
// wrapping modulo NUM_REQ.
module uart_rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IW-1:0]      ptr,
  output logic               hit,
  output logic [IW-1:0]      idx
);

  logic [IW-1:0] j;

  // Scan from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (elig[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter between NUM_REQ byte
// sources, with optional packet locking and a lock-abandon timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int LOCK_TIMEOUT = 1024,
  localparam int IW           = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0][7:0] req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  input  logic [NUM_REQ-1:0]      req_lock,
  input  logic [NUM_REQ-1:0][1:0] cfg_frame_type,
  input  logic [NUM_REQ-1:0][1:0] cfg_parity_type,
  input  logic [NUM_REQ-1:0]      cfg_stop_type,
  output logic [NUM_REQ-1:0]      req_ready,
  uart_tx_arbiter_if.master       tx,
  output logic [IW-1:0]           grant_id,
  output logic                    locked,
  output logic                    lock_timeout
);

  localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, gid_q, pick_idx;
  logic [NUM_REQ-1:0]  elig, gid_oh;
  logic                pick_hit, grant, accept;
  logic                req_q, locked_q, lock_to_q;
  logic [7:0]          data_q;
  tx_cfg_t             cfg_q;
  logic [CW-1:0]       to_cnt_q;

  assign gid_oh = NUM_REQ'(1) << gid_q;
  assign elig   = locked_q ? (req_valid & gid_oh) : req_valid;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .elig (elig),
    .ptr  (ptr_q),
    .hit  (pick_hit),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    accept    = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE:  if (en && !tx.tx_busy && pick_hit) begin
               grant   = 1'b1;
               state_d = ISSUE;
             end
      ISSUE: if (tx.tx_clr) begin
               accept    = 1'b1;
               req_ready = gid_oh;
               state_d   = DRAIN;
             end
      DRAIN: if (!tx.tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) state_q <= IDLE;
    else         state_q <= state_d;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      req_q     <= 1'b0;
      data_q    <= '0;
      cfg_q     <= '{frame: FRAME_RST, parity: PAR_NONE, stop: 1'b0};
      gid_q     <= '0;
      ptr_q     <= IW'(NUM_REQ - 1);
      locked_q  <= 1'b0;
      lock_to_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      lock_to_q <= 1'b0;
      if (grant) begin
        req_q  <= 1'b1;
        data_q <= req_data[pick_idx];
        cfg_q  <= '{frame:  frame_type_e'(cfg_frame_type[pick_idx]),
                    parity: parity_type_e'(cfg_parity_type[pick_idx]),
                    stop:   cfg_stop_type[pick_idx]};
        gid_q  <= pick_idx;
      end
      if (accept) begin
        req_q <= 1'b0;
        ptr_q <= gid_q;
        if (req_last[gid_q])      locked_q <= 1'b0;
        else if (req_lock[gid_q]) locked_q <= 1'b1;
      end
      // Owner went quiet while holding the lock: count, then abandon it.
      if (state_q == IDLE && locked_q && !req_valid[gid_q]) begin
        if (LOCK_TIMEOUT != 0 && to_cnt_q == TO_LAST) begin
          locked_q  <= 1'b0;
          lock_to_q <= 1'b1;
          to_cnt_q  <= '0;
        end else begin
          to_cnt_q  <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  assign tx.tx_req         = req_q;
  assign tx.tx_data        = data_q;
  assign tx.tx_frame_type  = cfg_q.frame;
  assign tx.tx_parity_type = cfg_q.parity;
  assign tx.tx_stop_type   = cfg_q.stop;
  assign grant_id          = gid_q;
  assign locked            = locked_q;
  assign lock_timeout      = lock_to_q;

endmodule
